// File: rtl/mult_seq_param.sv
// Sequential digit-serial unsigned multiplier: WIDTH x WIDTH -> 2*WIDTH, one DIGIT x DIGIT pair per RUN cycle.
// Optional macro MULT_SEQ_ZERO_SKIP_EN skips digit pairs where either digit is zero.
module mult_seq_param #(
  parameter int WIDTH = 32,
  parameter int DIGIT = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product,
  output logic [1:0]           state_dbg
);

  localparam int NDIG = WIDTH / DIGIT;
  localparam int NP   = NDIG * NDIG;
  localparam int KW   = (NDIG > 1) ? $clog2(NDIG) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t               r_state, w_next;
  logic [WIDTH-1:0]     r_a, r_b;
  logic [NP-1:0]        r_pending, w_mask, w_sel;
  logic [2*WIDTH-1:0]   r_product, w_pp;
  logic [KW-1:0]        w_i, w_j;
  logic [DIGIT-1:0]     w_da, w_db;
  logic [2*DIGIT-1:0]   w_dprod;

  // Pending pair mask built from the captured operands; bit k = (i=k/NDIG, j=k%NDIG).
  always_comb begin
    w_mask = '0;
    for (int i = 0; i < NDIG; i++) begin
      for (int j = 0; j < NDIG; j++) begin
`ifdef MULT_SEQ_ZERO_SKIP_EN
        w_mask[i*NDIG+j] = (r_a[i*DIGIT +: DIGIT] != '0) && (r_b[j*DIGIT +: DIGIT] != '0);
`else
        w_mask[i*NDIG+j] = 1'b1;
`endif
      end
    end
  end

  // Lowest set pending bit wins: scan from the top so the last hit is the lowest.
  always_comb begin
    w_i   = '0;
    w_j   = '0;
    w_sel = '0;
    for (int k = NP - 1; k >= 0; k--) begin
      if (r_pending[k]) begin
        w_i      = KW'(k / NDIG);
        w_j      = KW'(k % NDIG);
        w_sel    = '0;
        w_sel[k] = 1'b1;
      end
    end
  end

  assign w_da    = r_a[int'(w_i)*DIGIT +: DIGIT];
  assign w_db    = r_b[int'(w_j)*DIGIT +: DIGIT];
  assign w_dprod = {{DIGIT{1'b0}}, w_da} * {{DIGIT{1'b0}}, w_db};
  assign w_pp    = (2*WIDTH)'(w_dprod) << (DIGIT * (int'(w_i) + int'(w_j)));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= IDLE;
      r_a       <= '0;
      r_b       <= '0;
      r_pending <= '0;
      r_product <= '0;
    end else begin
      r_state <= w_next;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_a <= a;
            r_b <= b;
          end
        end
        LOAD: begin
          r_product <= '0;
          r_pending <= w_mask;
        end
        RUN: begin
          r_product <= r_product + w_pp;
          r_pending <= r_pending & ~w_sel;
        end
        default: ;
      endcase
    end
  end

  // Next-state and status outputs; LOAD looks at the mask it is about to register.
  always_comb begin
    w_next = r_state;
    busy   = 1'b0;
    done   = 1'b0;
    case (r_state)
      IDLE: if (start) w_next = LOAD;
      LOAD: begin
        busy   = 1'b1;
        w_next = (w_mask != '0) ? RUN : DONE;
      end
      RUN: begin
        busy = 1'b1;
        if ((r_pending & ~w_sel) == '0) w_next = DONE;
      end
      DONE: begin
        done   = 1'b1;
        w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  assign product   = r_product;
  assign state_dbg = r_state;

endmodule

// File: tb/tb_mult_seq_param.sv
// Directed bench for mult_seq_param: driver pushes expected product and done cycle, a negedge monitor pops and checks.
// Handshake: start is sampled only in IDLE; done is a one-cycle pulse during which product is valid and busy is low.
module tb_mult_seq_param;
  localparam int W = 32;

`ifdef MULT_SEQ_ZERO_SKIP_EN
  localparam bit SKIP = 1'b1;
`else
  localparam bit SKIP = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           reset;
  logic           start;
  logic [W-1:0]   a, b;
  logic           busy, done;
  logic [2*W-1:0] product;
  logic [1:0]     state_dbg;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  logic [2*W-1:0] exp_q[$];
  int             exp_cyc_q[$];

  mult_seq_param #(.WIDTH(W), .DIGIT(16)) dut (
    .clk(clk), .reset(reset), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .product(product), .state_dbg(state_dbg)
  );

  // Clock / reset block
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [2*W-1:0] act, input logic [2*W-1:0] expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (reset === 1'b0 && done === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_done", 64'(1), 64'(0));
      end else begin
        check("product", product, exp_q.pop_front());
        check("done_cycle", 64'(cyc), 64'(exp_cyc_q.pop_front()));
        check("busy_at_done", 64'(busy), 64'(0));
      end
    end
  end

  task automatic wait_drain(input string name);
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 60) begin
      @(negedge clk); #1;
      t++;
    end
    if (exp_q.size() != 0) begin
      check({name, "_timeout"}, 64'(exp_q.size()), 64'(0));
      exp_q.delete();
      exp_cyc_q.delete();
    end
  endtask

  // Driver: one start pulse, expected done at start cycle + P + 2.
  task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv,
                        input logic [2*W-1:0] expv, input int p_skip, input string name);
    int p;
    p = SKIP ? p_skip : 4;
    @(negedge clk); #1;
    a = av; b = bv; start = 1'b1;
    exp_q.push_back(expv);
    exp_cyc_q.push_back(cyc + p + 2);
    @(negedge clk); #1;
    start = 1'b0;
    wait_drain(name);
  endtask

  initial begin
    int c0;
    reset = 1'b1; start = 1'b0; a = '0; b = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_done", 64'(done), 64'(0));
    check("rst_product", product, 64'(0));
    check("rst_state", 64'(state_dbg), 64'(0));
    #1 reset = 1'b0;

    run_op(32'h0000_1234, 32'h0000_5678, 64'h0000_0000_0626_0060, 1, "small");
    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 4, "max");
    run_op(32'h0001_0000, 32'h0000_0003, 64'h0000_0000_0003_0000, 1, "hi_lo");
    run_op(32'h0000_0000, 32'h1234_5678, 64'h0, 0, "zero");
    run_op(32'h0003_0000, 32'h0005_0000, 64'h0000_000F_0000_0000, 1, "hi_hi");

    // start during LOAD must be ignored, operands unchanged, no second result
    @(negedge clk); #1;
    a = 32'h2; b = 32'h3; start = 1'b1;
    exp_q.push_back(64'd6);
    exp_cyc_q.push_back(cyc + (SKIP ? 1 : 4) + 2);
    @(negedge clk); #1;
    a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF; start = 1'b1;
    @(negedge clk); #1;
    start = 1'b0;
    wait_drain("busy_start");
    repeat (8) @(negedge clk);

    // start held high: accepted in every IDLE cycle, next at P+3
    @(negedge clk); #1;
    a = 32'h0000_00FF; b = 32'h0000_0101; start = 1'b1;
    c0 = cyc;
    exp_q.push_back(64'h0000_0000_0000_FFFF);
    exp_cyc_q.push_back(c0 + (SKIP ? 1 : 4) + 2);
    exp_q.push_back(64'h0000_0000_0000_FFFF);
    exp_cyc_q.push_back(c0 + 2 * (SKIP ? 1 : 4) + 5);
    while (cyc < c0 + (SKIP ? 1 : 4) + 4) begin
      @(negedge clk); #1;
    end
    start = 1'b0;
    wait_drain("back2back");

    // reset mid-operation abandons it; start at cycle 3 ignored
    @(negedge clk); #1;
    a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF; start = 1'b1;
    @(negedge clk); #1; start = 1'b0;
    @(negedge clk); #1;
    @(negedge clk); #1; a = 32'h5; b = 32'h7; start = 1'b1;
    @(negedge clk); #1; start = 1'b0;
    check("busy_before_reset", 64'(busy), 64'(1));
    check("state_before_reset", 64'(state_dbg), 64'(2));
    reset = 1'b1;
    @(negedge clk); #1; reset = 1'b0;
    check("midrst_busy", 64'(busy), 64'(0));
    check("midrst_product", product, 64'(0));
    check("midrst_state", 64'(state_dbg), 64'(0));
    repeat (8) @(negedge clk);
    run_op(32'h2, 32'h3, 64'd6, 1, "after_reset");

    repeat (3) @(negedge clk);
    check("queue_empty", 64'(exp_q.size()), 64'(0));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "timeout");
  end
endmodule
